// File: rtl/div_mod_reconstruct.sv
// Rebuilds a dividend from divider results: dividend = quotient * divisor + remainder.
// Radix-2 shift-add over 17 cycles, then one sign-fix/add cycle; one result per 19 cycles.
module div_mod_reconstruct (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [16:0] quotient_i,
  input  logic [15:0] divisor_i,
  input  logic [15:0] remainder_i,
  input  logic        mode_i,
  input  logic        valid_input_i,
  output logic        busy_o,
  output logic        valid_output_o,
  output logic [31:0] dividend_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [16:0] mplr_q, mplr_d;
  logic [15:0] mcand_q, mcand_d;
  logic        sign_q, sign_d;
  logic [15:0] rem_q, rem_d;
  logic        mode_q, mode_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        vout_q, vout_d;
  logic [31:0] dividend_q, dividend_d;
  logic        ovf_q, ovf_d;

  logic [33:0] prod_ext, prod_signed, rem_ext, sum;

  // Magnitudes of -65536 / -32768 fit unsigned in 17 / 16 bits.
  logic [16:0] q_abs;
  logic [15:0] d_abs;
  assign q_abs = quotient_i[16] ? (~quotient_i + 17'd1) : quotient_i;
  assign d_abs = divisor_i[15]  ? (~divisor_i + 16'd1)  : divisor_i;

  assign prod_ext    = {2'b00, acc_q};
  assign prod_signed = sign_q ? (~prod_ext + 34'd1) : prod_ext;
  assign rem_ext     = mode_q ? 34'd0 : {{18{rem_q[15]}}, rem_q};
  assign sum         = prod_signed + rem_ext;

  always_comb begin
    state_d    = state_q;
    mplr_d     = mplr_q;
    mcand_d    = mcand_q;
    sign_d     = sign_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    vout_d     = 1'b0;
    dividend_d = dividend_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (valid_input_i) begin
          mplr_d  = q_abs;
          mcand_d = d_abs;
          sign_d  = quotient_i[16] ^ divisor_i[15];
          rem_d   = remainder_i;
          mode_d  = mode_i;
          acc_d   = 32'd0;
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (mplr_q[0]) acc_d = acc_q + ({16'd0, mcand_q} << cnt_q);
        mplr_d = {1'b0, mplr_q[16:1]};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd16) state_d = S_FIX;
      end
      S_FIX: begin
        dividend_d = sum[31:0];
        ovf_d      = !((sum[33:31] == 3'b000) || (sum[33:31] == 3'b111));
        vout_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      mplr_q     <= 17'd0;
      mcand_q    <= 16'd0;
      sign_q     <= 1'b0;
      rem_q      <= 16'd0;
      mode_q     <= 1'b0;
      acc_q      <= 32'd0;
      cnt_q      <= 5'd0;
      busy_q     <= 1'b0;
      vout_q     <= 1'b0;
      dividend_q <= 32'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mplr_q     <= mplr_d;
      mcand_q    <= mcand_d;
      sign_q     <= sign_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      vout_q     <= vout_d;
      dividend_q <= dividend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy_o         = busy_q;
  assign valid_output_o = vout_q;
  assign dividend_o     = dividend_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_div_mod_reconstruct.sv
// Directed-vector bench for div_mod_reconstruct with hand-computed results.
module tb_div_mod_reconstruct;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] q;
  logic [15:0] d, r;
  logic        mode, vin;
  logic        busy, vout, ovf;
  logic [31:0] dvd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_mod_reconstruct dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .quotient_i     (q),
    .divisor_i      (d),
    .remainder_i    (r),
    .mode_i         (mode),
    .valid_input_i  (vin),
    .busy_o         (busy),
    .valid_output_o (vout),
    .dividend_o     (dvd),
    .overflow_o     (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drives one strobe; returns just after the sampling edge E.
  task automatic strobe(input logic [16:0] qq, input logic [15:0] dd, input logic [15:0] rr,
                        input logic m);
    @(negedge clk);
    q = qq; d = dd; r = rr; mode = m; vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
  endtask

  // Counts edges until valid_output is seen (bounded); also counts busy drops before it.
  task automatic wait_pulse(output int n, output int drops);
    int i;
    n = 0;
    drops = 0;
    i = 0;
    while (n == 0 && i < 30) begin
      @(posedge clk);
      #1;
      i++;
      if (vout) n = i;
      else if (!busy) drops++;
    end
  endtask

  task automatic run_op(input string tag, input logic [16:0] qq, input logic [15:0] dd,
                        input logic [15:0] rr, input logic m,
                        input logic [31:0] exp_div, input logic exp_ovf);
    int n, drops;
    strobe(qq, dd, rr, m);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_pulse(n, drops);
    check({tag, "_lat"}, n, 32'd18);
    check({tag, "_busyhold"}, drops, 32'd0);
    check({tag, "_div"}, dvd, exp_div);
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_pulse1"}, {31'd0, vout}, 32'd0);
    check({tag, "_divhold"}, dvd, exp_div);
  endtask

  initial begin
    int n, drops, seen;
    rst = 1'b1; vin = 1'b0; q = '0; d = '0; r = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_vout", {31'd0, vout}, 32'd0);
    check("rst_div",  dvd, 32'd0);
    check("rst_ovf",  {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("pos",     17'd7,       16'd5,      16'd3,      1'b0, 32'd38,        1'b0);
    run_op("negq",    17'h1FFF9,   16'd5,      16'hFFFD,   1'b0, 32'hFFFFFFDA,  1'b0);
    run_op("negqd",   17'h1FFF9,   16'hFFFB,   16'd3,      1'b0, 32'd38,        1'b0);
    run_op("maxpos",  17'h10000,   16'h8000,   16'd0,      1'b0, 32'h80000000,  1'b1);
    run_op("maxpos_m1", 17'h10000, 16'h8000,   16'hFFFF,   1'b0, 32'h7FFFFFFF,  1'b0);
    run_op("maxpos_p5", 17'h10000, 16'h8000,   16'd5,      1'b0, 32'h80000005,  1'b1);
    run_op("maxneg",  17'h10000,   16'd32767,  16'h8000,   1'b0, 32'h80008000,  1'b0);
    run_op("mode1",   17'd100,     16'hFFFD,   16'd999,    1'b1, 32'hFFFFFED4,  1'b0);
    run_op("zeroq",   17'd0,       16'd1234,   16'hFFFB,   1'b0, 32'hFFFFFFFB,  1'b0);

    // Strobe while busy is ignored; back-to-back strobe in the pulse cycle is accepted.
    strobe(17'd1000, 16'd1000, 16'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    q = 17'd1; vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    wait_pulse(n, drops);
    check("ign_lat", n + 5, 32'd18);
    check("ign_div", dvd, 32'd1000000);
    q = 17'd3; d = 16'd4; r = 16'd1; mode = 1'b0; vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_vout", {31'd0, vout}, 32'd0);
    wait_pulse(n, drops);
    check("b2b_lat", n, 32'd18);
    check("b2b_div", dvd, 32'd13);

    // Reset mid-operation aborts with no result pulse.
    strobe(17'd500, 16'd500, 16'd0, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_vout", {31'd0, vout}, 32'd0);
    check("abort_div",  dvd, 32'd0);
    check("abort_ovf",  {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (vout) seen++;
    end
    check("abort_nopulse", seen, 32'd0);
    run_op("post_rst", 17'd2, 16'd3, 16'd1, 1'b0, 32'd7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
